// File: rtl/fifo_fwft_burst_reader.sv
// Drains a first-word-fall-through FIFO into fixed-length valid/ready bursts.
// A short burst drains leftover words when flush is raised or the idle timeout expires.
module fifo_fwft_burst_reader #(
    parameter int C_DATA_WIDTH = 128,
    parameter int C_BURST_LEN  = 8,
    parameter int C_TIMEOUT    = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [C_DATA_WIDTH-1:0] fifo_dataout,
    input  logic                    fifo_empty,
    input  logic [17:0]             fifo_count,
    output logic                    fifo_rden,
    input  logic                    flush,
    output logic [C_DATA_WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [15:0]             m_len,
    output logic                    busy,
    output logic [31:0]             burst_cnt
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    localparam logic [17:0] FULL_CNT = 18'(C_BURST_LEN);
    localparam logic [31:0] TO_LAST  = (C_TIMEOUT == 0) ? 32'd0 : 32'(C_TIMEOUT - 1);
    localparam bit          TO_EN    = (C_TIMEOUT != 0);

    state_t      state, state_nx;
    logic [15:0] rem, rem_nx, len_nx;
    logic [31:0] timer, timer_nx, burst_cnt_nx;
    logic        has_data, start_full, start_short;

    assign has_data    = (fifo_count != 18'd0);
    assign start_full  = (fifo_count >= FULL_CNT);
    // Short bursts only cover residue below one full burst; a full burst always wins.
    assign start_short = has_data && !start_full && (flush || (TO_EN && timer == TO_LAST));

    assign m_data = fifo_dataout;
    assign busy   = (state == S_BURST);

    always_comb begin
        state_nx     = state;
        rem_nx       = rem;
        len_nx       = m_len;
        timer_nx     = timer;
        burst_cnt_nx = burst_cnt;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        fifo_rden    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_full) begin
                    state_nx = S_BURST;
                    len_nx   = 16'(C_BURST_LEN);
                    rem_nx   = 16'(C_BURST_LEN);
                    timer_nx = 32'd0;
                end else if (start_short) begin
                    state_nx = S_BURST;
                    len_nx   = fifo_count[15:0];
                    rem_nx   = fifo_count[15:0];
                    timer_nx = 32'd0;
                end else if (!has_data) begin
                    timer_nx = 32'd0;
                end else begin
                    timer_nx = timer + 32'd1;
                end
            end
            S_BURST: begin
                timer_nx = 32'd0;
                // Valid follows empty so a lagging empty flag just stalls the beat.
                m_valid   = ~fifo_empty;
                m_last    = (rem == 16'd1);
                fifo_rden = m_valid & m_ready;
                if (fifo_rden) begin
                    rem_nx = rem - 16'd1;
                    if (m_last) begin
                        state_nx     = S_IDLE;
                        burst_cnt_nx = burst_cnt + 32'd1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rem       <= 16'd0;
            m_len     <= 16'd0;
            timer     <= 32'd0;
            burst_cnt <= 32'd0;
        end else begin
            state     <= state_nx;
            rem       <= rem_nx;
            m_len     <= len_nx;
            timer     <= timer_nx;
            burst_cnt <= burst_cnt_nx;
        end
    end

endmodule

// File: tb/tb_fifo_fwft_burst_reader.sv
// Bench for fifo_fwft_burst_reader: FWFT FIFO model with lagging empty, burst-level
// reference model, per-cycle compare, directed scenarios and a random phase.
module tb_fifo_fwft_burst_reader;
    localparam int DW = 128;
    localparam int BL = 8;
    localparam int TO = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] fifo_dataout = '0;
    logic          fifo_empty = 1'b1;
    logic [17:0]   fifo_count = '0;
    logic          fifo_rden;
    logic          flush = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic [15:0]   m_len;
    logic          busy;
    logic [31:0]   burst_cnt;

    fifo_fwft_burst_reader #(.C_DATA_WIDTH(DW), .C_BURST_LEN(BL), .C_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .fifo_dataout(fifo_dataout), .fifo_empty(fifo_empty),
        .fifo_count(fifo_count), .fifo_rden(fifo_rden), .flush(flush), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_len(m_len),
        .busy(busy), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    int cmp_n = 0;
    int err_n = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // FIFO contents, words queued for writing, and the expected output stream
    logic [DW-1:0] fq[$];
    logic [DW-1:0] pend_q[$];
    logic [DW-1:0] sb[$];
    int lag_n = 1;
    int lag_cnt = 0;

    // accepted-beat log for literal checks
    logic [DW-1:0] log_d[$];
    logic          log_l[$];
    logic [15:0]   log_n[$];

    // burst-level reference model
    bit          chk_en = 0;
    bit          md_busy = 0;
    int          md_rem = 0;
    logic [15:0] md_len = '0;
    int          md_timer = 0;
    logic [31:0] md_bursts = '0;

    always @(posedge clk) begin
        bit was_empty;
        bit acc;
        int cnt;
        // reference model step, using the values present just before this edge
        cnt = int'(fifo_count);
        acc = md_busy && !fifo_empty && m_ready;
        if (acc && sb.size() > 0) void'(sb.pop_front());
        if (rst) begin
            chk_en = 1; md_busy = 0; md_rem = 0; md_len = '0; md_timer = 0; md_bursts = '0;
        end else if (md_busy) begin
            md_timer = 0;
            if (acc) begin
                if (md_rem == 1) begin
                    md_busy = 0;
                    md_bursts = md_bursts + 32'd1;
                end
                md_rem--;
            end
        end else if (cnt >= BL) begin
            md_busy = 1; md_rem = BL; md_len = 16'(BL); md_timer = 0;
        end else if (cnt > 0 && (flush || (TO != 0 && md_timer == TO - 1))) begin
            md_busy = 1; md_rem = cnt; md_len = 16'(cnt); md_timer = 0;
        end else if (cnt == 0) begin
            md_timer = 0;
        end else begin
            md_timer++;
        end

        // FIFO model
        if (fifo_rden) begin
            log_d.push_back(m_data);
            log_l.push_back(m_last);
            log_n.push_back(m_len);
            cmp_n++;
            if (fq.size() == 0) begin
                err_n++;
                $display("FAIL underrun: pop from empty FIFO at %0t", $time);
            end else begin
                void'(fq.pop_front());
            end
        end
        was_empty = (fq.size() == 0);
        while (pend_q.size() > 0) begin
            logic [DW-1:0] w;
            w = pend_q.pop_front();
            fq.push_back(w);
            sb.push_back(w);
        end
        if (was_empty && fq.size() > 0) lag_cnt = lag_n;
        else if (lag_cnt > 0) lag_cnt--;
        fifo_count   <= 18'(fq.size());
        fifo_empty   <= (fq.size() == 0) || (lag_cnt > 0);
        fifo_dataout <= (fq.size() > 0) ? fq[0] : '0;
    end

    // per-cycle compare, mid-cycle after inputs have settled
    always begin
        bit ev;
        @(negedge clk);
        #2;
        if (chk_en) begin
            ev = md_busy && !fifo_empty;
            chk("busy", DW'(busy), DW'(md_busy));
            chk("m_len", DW'(m_len), DW'(md_len));
            chk("burst_cnt", DW'(burst_cnt), DW'(md_bursts));
            chk("m_valid", DW'(m_valid), DW'(ev));
            chk("m_last", DW'(m_last), DW'(md_busy && md_rem == 1));
            chk("fifo_rden", DW'(fifo_rden), DW'(ev && m_ready));
            if (ev && sb.size() > 0) chk("m_data", m_data, sb[0]);
        end
    end

    task automatic wr(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            pend_q.push_back(DW'(base + i));
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input logic [31:0] target, input int budget, input string nm);
        int n;
        n = 0;
        while (!(burst_cnt == target && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        cmp_n++;
        if (n >= budget) begin
            err_n++;
            $display("FAIL %s: timeout, burst_cnt %0d expected %0d", nm, burst_cnt, target);
        end
    endtask

    task automatic chk_last(input string nm, input int len, input int tag);
        int k;
        k = log_d.size() - 1;
        cmp_n++;
        if (k < 0) begin
            err_n++;
            $display("FAIL %s: no beats logged", nm);
        end else begin
            chk({nm, " len"}, DW'(log_n[k]), DW'(len));
            chk({nm, " data"}, log_d[k], DW'(tag));
            chk({nm, " last"}, DW'(log_l[k]), DW'(1));
        end
    endtask

    initial begin
        int base, n;
        repeat (3) @(negedge clk);
        chk("reset busy", DW'(busy), DW'(0));
        chk("reset m_valid", DW'(m_valid), DW'(0));
        chk("reset burst_cnt", DW'(burst_cnt), DW'(0));
        chk("reset m_len", DW'(m_len), DW'(0));
        rst = 1'b0;

        // 1: one full burst of 0..7
        m_ready = 1'b1;
        wr(8, 0);
        wait_done(32'd1, 100, "t1");
        chk("t1 beats", DW'(log_d.size()), DW'(8));
        for (int i = 0; i < 8 && i < log_d.size(); i++) begin
            chk("t1 data", log_d[i], DW'(i));
            chk("t1 last", DW'(log_l[i]), DW'(i == 7));
            chk("t1 len", DW'(log_n[i]), DW'(8));
        end
        chk("t1 count", DW'(fifo_count), DW'(0));

        // 2: 20 words -> 8, 8, then a timed-out short burst of 4
        wr(20, 100);
        wait_done(32'd4, 700, "t2");
        chk_last("t2", 4, 119);

        // 3: 3 words then a one-cycle flush pulse
        wr(3, 200);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_done(32'd5, 20, "t3");
        chk_last("t3", 3, 202);

        // 4: full burst under a 1,0,0,1 ready pattern
        m_ready = 1'b0;
        base = log_d.size();
        wr(8, 300);
        n = 0;
        while (!(burst_cnt == 32'd6 && !busy) && n < 80) begin
            m_ready = (n % 4 == 0) || (n % 4 == 3);
            @(negedge clk);
            n++;
        end
        chk("t4 done", DW'(burst_cnt), DW'(6));
        chk("t4 beats", DW'(log_d.size() - base), DW'(8));
        for (int i = 0; i < 8 && base + i < log_d.size(); i++)
            chk("t4 data", log_d[base + i], DW'(300 + i));

        // 5: 8 words land at once while empty lags, first beat stalls
        m_ready = 1'b1;
        lag_n = 2;
        pend_q.push_back(DW'(400)); pend_q.push_back(DW'(401)); pend_q.push_back(DW'(402));
        pend_q.push_back(DW'(403)); pend_q.push_back(DW'(404)); pend_q.push_back(DW'(405));
        pend_q.push_back(DW'(406)); pend_q.push_back(DW'(407));
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5 busy", DW'(busy), DW'(1));
        chk("t5 stall", DW'(m_valid), DW'(0));
        @(negedge clk);
        chk("t5 go", DW'(m_valid), DW'(1));
        wait_done(32'd7, 40, "t5");
        chk_last("t5", 8, 407);
        lag_n = 1;

        // 6: reset after beat 3, the 5 leftovers drain after the timeout
        base = log_d.size();
        wr(8, 600);
        n = 0;
        while (log_d.size() - base < 3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        m_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6 busy", DW'(busy), DW'(0));
        chk("t6 m_valid", DW'(m_valid), DW'(0));
        chk("t6 burst_cnt", DW'(burst_cnt), DW'(0));
        chk("t6 count", DW'(fifo_count), DW'(5));
        m_ready = 1'b1;
        wait_done(32'd1, 400, "t6");
        chk_last("t6", 5, 607);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0 && fq.size() < 200)
                pend_q.push_back({$urandom, $urandom, $urandom, 32'(i)});
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 40) == 0);
            rst     = ($urandom_range(0, 700) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        m_ready = 1'b1;
        flush = 1'b1;
        n = 0;
        while (!(fifo_count == 18'd0 && !busy && pend_q.size() == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain count", DW'(fifo_count), DW'(0));
        flush = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end
endmodule
